multi_cycle_ctrl: RTL

EX-stage sequencer for the shared multi-cycle arithmetic unit (MULT/MULTU/MADD/MSUB/DIV/DIVU).
- Latches operands when a multi-cycle instruction enters EX.
- Drives the unit with stable inputs and stalls the pipeline until the result is ready.
- Issues a single-cycle HI/LO write-back.
- Aborts cleanly on exception flush.

---
 rtl/multi_cycle_ctrl_pkg.sv | 30 +++
 rtl/multi_cycle_ctrl_if.sv | 31 +++
 rtl/multi_cycle_ctrl_counter.sv | 30 +++
 rtl/multi_cycle_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the EX-stage multi-cycle arithmetic sequencer:
// instruction codes, sequencer state encoding and the op-class helpers.
package multi_cycle_ctrl_pkg;

    localparam logic [7:0] INST_NOP   = 8'h00;
    localparam logic [7:0] INST_MULT  = 8'h18;
    localparam logic [7:0] INST_MULTU = 8'h19;
    localparam logic [7:0] INST_DIV   = 8'h1A;
    localparam logic [7:0] INST_DIVU  = 8'h1B;
    localparam logic [7:0] INST_MADD  = 8'h1C;
    localparam logic [7:0] INST_MSUB  = 8'h1D;
    localparam logic [7:0] INST_ADD   = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } mc_state_t;

    function automatic logic mc_class_div(input logic [7:0] inst);
        return (inst == INST_DIV) || (inst == INST_DIVU);
    endfunction

    function automatic logic mc_class_mul(input logic [7:0] inst);
        return (inst == INST_MULT) || (inst == INST_MULTU) ||
               (inst == INST_MADD) || (inst == INST_MSUB);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Bundle between the EX stage / multi-cycle unit and the sequencer.
// master = pipeline and arithmetic unit side, slave = sequencer.
interface multi_cycle_ctrl_if;

    logic [7:0]  inst_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [63:0] hilo_i;
    logic        flush;
    logic [63:0] unit_result;
    logic        unit_done;
    logic [7:0]  unit_inst;
    logic [31:0] unit_op1;
    logic [31:0] unit_op2;
    logic [63:0] unit_hilo;
    logic        stall_req;
    logic        hilo_we;
    logic [63:0] hilo_o;
    logic        busy;

    modport master (
        output inst_i, op1_i, op2_i, hilo_i, flush, unit_result, unit_done,
        input  unit_inst, unit_op1, unit_op2, unit_hilo, stall_req, hilo_we, hilo_o, busy
    );

    modport slave (
        input  inst_i, op1_i, op2_i, hilo_i, flush, unit_result, unit_done,
        output unit_inst, unit_op1, unit_op2, unit_hilo, stall_req, hilo_we, hilo_o, busy
    );

endinterface

// File: rtl/multi_cycle_ctrl_counter.sv
// Loadable down-counter that saturates at zero; clear beats load beats decrement.
module mc_down_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// EX-stage sequencer for the shared MULT/DIV unit: latches operands, stalls
// the pipeline while the unit works, then issues one HI/LO write-back.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 36,
    parameter int MUL_CYCLES = 2,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    multi_cycle_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] LP_DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LP_MUL_LOAD = CNT_W'(MUL_CYCLES);

    mc_state_t        r_state;
    mc_state_t        w_state_nxt;

    logic [7:0]       r_unit_inst;
    logic [31:0]      r_unit_op1;
    logic [31:0]      r_unit_op2;
    logic [63:0]      r_unit_hilo;
    logic [63:0]      r_hilo_o;

    logic             w_inst_div;
    logic             w_inst_mc;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero;
    logic             w_cnt_last;
    logic             w_launch;
    logic             w_complete;
    logic             w_cnt_clear;
    logic             w_cnt_dec;
    logic             w_stall;
    logic             w_hilo_we;

    assign w_inst_div     = mc_class_div(bus.inst_i);
    assign w_inst_mc      = w_inst_div || mc_class_mul(bus.inst_i);
    assign w_cnt_load_val = w_inst_div ? LP_DIV_LOAD : LP_MUL_LOAD;
    // The count is loaded with the number of BUSY cycles, so the last one sees 1.
    assign w_cnt_last     = (w_cnt == CNT_W'(1)) || w_cnt_zero;

    mc_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cnt_clear),
        .i_load     (w_launch),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_complete  = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_dec   = 1'b0;
        w_stall     = 1'b0;
        w_hilo_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_inst_mc && !bus.flush) begin
                    w_launch    = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall   = 1'b1;
                w_cnt_dec = 1'b1;
                if (bus.flush) begin
                    w_cnt_clear = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_last || (mc_class_div(r_unit_inst) && bus.unit_done)) begin
                    w_complete  = 1'b1;
                    w_cnt_clear = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // The commit was decided on the previous edge, so a flush here
                // only shortens the return path, it does not cancel the write.
                w_hilo_we   = 1'b1;
                w_state_nxt = bus.flush ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_unit_inst <= INST_NOP;
            r_unit_op1  <= '0;
            r_unit_op2  <= '0;
            r_unit_hilo <= '0;
            r_hilo_o    <= '0;
        end else begin
            if (w_launch) begin
                r_unit_inst <= bus.inst_i;
                r_unit_op1  <= bus.op1_i;
                r_unit_op2  <= bus.op2_i;
                r_unit_hilo <= bus.hilo_i;
            end else if (w_cnt_clear) begin
                r_unit_inst <= INST_NOP;
            end
            if (w_complete) begin
                r_hilo_o <= bus.unit_result;
            end
        end
    end

    assign bus.unit_inst = r_unit_inst;
    assign bus.unit_op1  = r_unit_op1;
    assign bus.unit_op2  = r_unit_op2;
    assign bus.unit_hilo = r_unit_hilo;
    assign bus.hilo_o    = r_hilo_o;
    assign bus.stall_req = w_stall;
    assign bus.hilo_we   = w_hilo_we;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule
